// File: rtl/mem_arb_pkg.sv
// Shared types and parameter defaults for the data/instruction memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned STARVE_LIM_DEF = 3;
  localparam int unsigned TIMEOUT_DEF    = 255;

  typedef enum logic [1:0] {
    IDLE,
    GNT_D,
    GNT_I,
    DONE
  } state_t;

  // Counter width able to hold 0..lim, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned lim);
    return (lim < 1) ? 1 : $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant decision: data wins ties unless the instruction side has been passed over STARVE_LIM times.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIM = STARVE_LIM_DEF,
  parameter int unsigned CNT_W      = cnt_width(STARVE_LIM)
) (
  input  logic             d_req_i,
  input  logic             i_req_i,
  input  logic [CNT_W-1:0] starve_cnt_i,
  output logic             pick_d_o,
  output logic             pick_i_o
);

  logic starved;

  always_comb begin
    starved  = i_req_i && (starve_cnt_i == CNT_W'(STARVE_LIM));
    pick_i_o = i_req_i && (!d_req_i || starved);
    pick_d_o = d_req_i && !pick_i_o;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (data/instruction cache) arbiter onto a single memory port with
// starvation control, grant watchdog and fully registered outputs.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_LIM = STARVE_LIM_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  input  logic              i_rd,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  output logic              mem_oe,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              bus_err
);

  localparam int unsigned SC_W = cnt_width(STARVE_LIM);
  localparam int unsigned WD_W = cnt_width(TIMEOUT);

  state_t            state_q, state_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              we_op_q, we_op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic              mem_oe_q, mem_oe_d;
  logic              mem_we_q, mem_we_d;
  logic              d_ready_q, d_ready_d;
  logic              i_ready_q, i_ready_d;
  logic              busy_q, busy_d;
  logic              bus_err_q, bus_err_d;

  logic pick_d, pick_i;
  logic in_grant, timeout_hit;

  mem_arb_pick #(
    .STARVE_LIM (STARVE_LIM),
    .CNT_W      (SC_W)
  ) u_pick (
    .d_req_i      (d_rd | d_wr),
    .i_req_i      (i_rd),
    .starve_cnt_i (starve_q),
    .pick_d_o     (pick_d),
    .pick_i_o     (pick_i)
  );

  assign in_grant    = (state_q == GNT_D) || (state_q == GNT_I);
  assign timeout_hit = in_grant && !mem_ready && (wdog_q == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:         if (pick_d) state_d = GNT_D;
                    else if (pick_i) state_d = GNT_I;
      GNT_D, GNT_I: if (mem_ready || timeout_hit) state_d = DONE;
      DONE:         state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they line up with it.
  always_comb begin
    starve_d  = starve_q;
    wdog_d    = wdog_q;
    we_op_d   = we_op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    d_rdata_d = d_rdata_q;
    i_rdata_d = i_rdata_q;
    bus_err_d = bus_err_q || timeout_hit;

    if (state_q == IDLE && state_d == GNT_D) begin
      addr_d  = d_addr;
      wdata_d = d_wdata;
      we_op_d = d_wr;
      wdog_d  = '0;
      if (i_rd && starve_q != SC_W'(STARVE_LIM)) starve_d = starve_q + 1'b1;
    end else if (state_q == IDLE && state_d == GNT_I) begin
      addr_d   = i_addr;
      wdata_d  = '0;
      we_op_d  = 1'b0;
      wdog_d   = '0;
      starve_d = '0;
    end else if (in_grant && state_d == state_q) begin
      wdog_d = wdog_q + 1'b1;
    end

    if (state_q == GNT_D && mem_ready && !we_op_q) d_rdata_d = mem_rdata;
    if (state_q == GNT_I && mem_ready)             i_rdata_d = mem_rdata;

    mem_oe_d  = (state_d == GNT_I) || (state_d == GNT_D && !we_op_d);
    mem_we_d  = (state_d == GNT_D) && we_op_d;
    d_ready_d = (state_q == GNT_D) && (state_d == DONE);
    i_ready_d = (state_q == GNT_I) && (state_d == DONE);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q  <= '0;
      wdog_q    <= '0;
      we_op_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      d_rdata_q <= '0;
      i_rdata_q <= '0;
      mem_oe_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      d_ready_q <= 1'b0;
      i_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      wdog_q    <= wdog_d;
      we_op_q   <= we_op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      d_rdata_q <= d_rdata_d;
      i_rdata_q <= i_rdata_d;
      mem_oe_q  <= mem_oe_d;
      mem_we_q  <= mem_we_d;
      d_ready_q <= d_ready_d;
      i_ready_q <= i_ready_d;
      busy_q    <= busy_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign d_rdata   = d_rdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_ready   = d_ready_q;
  assign i_ready   = i_ready_q;
  assign mem_oe    = mem_oe_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_rd, d_wr, i_rd, mem_ready;
  logic [31:0] d_addr, d_wdata, i_addr, mem_rdata;
  logic [31:0] d_rdata, i_rdata, mem_addr, mem_wdata;
  logic        d_ready, i_ready, mem_oe, mem_we, busy, bus_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  mem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_LIM (3),
    .TIMEOUT    (255)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .d_rd      (d_rd),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .i_rd      (i_rd),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ready   (i_ready),
    .mem_oe    (mem_oe),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int unsigned oe_cnt;
    int unsigned done_at;
    logic exp_d, exp_i;

    reset = 1'b1;
    d_rd = 1'b0; d_wr = 1'b0; i_rd = 1'b0; mem_ready = 1'b0;
    d_addr = '0; d_wdata = '0; i_addr = '0; mem_rdata = '0;
    tick(); tick();
    check_eq("rst_mem_oe", mem_oe, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_bus_err", bus_err, 0);
    check_eq("rst_ready", {d_ready, i_ready}, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_rdata", {d_rdata, i_rdata}, 0);
    reset = 1'b0;

    // Single instruction read, mem_ready in cycle 3
    i_rd = 1'b1; i_addr = 32'h40; mem_rdata = 32'h1234_5678;
    tick();
    check_eq("ird_c1_oe", mem_oe, 1);
    check_eq("ird_c1_we", mem_we, 0);
    check_eq("ird_c1_addr", mem_addr, 32'h40);
    check_eq("ird_c1_busy", busy, 1);
    tick();
    check_eq("ird_c2_oe", mem_oe, 1);
    tick();
    check_eq("ird_c3_oe", mem_oe, 1);
    check_eq("ird_c3_rdy", i_ready, 0);
    mem_ready = 1'b1;
    tick();
    check_eq("ird_c4_oe", mem_oe, 0);
    check_eq("ird_c4_rdy", i_ready, 1);
    check_eq("ird_c4_rdata", i_rdata, 32'h1234_5678);
    i_rd = 1'b0; mem_ready = 1'b0;
    tick();
    check_eq("ird_c5_rdy", i_ready, 0);
    check_eq("ird_c5_busy", busy, 0);

    // Simultaneous d_wr and d_rd: write wins
    d_rd = 1'b1; d_wr = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF; mem_rdata = 32'h0000_0BAD;
    tick();
    check_eq("dwr_we", mem_we, 1);
    check_eq("dwr_oe", mem_oe, 0);
    check_eq("dwr_addr", mem_addr, 32'h10);
    check_eq("dwr_wdata", mem_wdata, 32'hDEAD_BEEF);
    mem_ready = 1'b1;
    tick();
    check_eq("dwr_done_we", mem_we, 0);
    check_eq("dwr_done_rdy", d_ready, 1);
    check_eq("dwr_rdata_kept", d_rdata, 0);
    d_rd = 1'b0; d_wr = 1'b0; mem_ready = 1'b0;
    tick();
    check_eq("dwr_rdy_pulse", d_ready, 0);

    // Back-to-back data reads; mem_ready left high (ignored outside grants)
    d_rd = 1'b1; d_addr = 32'h20; mem_rdata = 32'hA1; mem_ready = 1'b1;
    tick();
    check_eq("b2b_g1_addr", mem_addr, 32'h20);
    check_eq("b2b_g1_oe", mem_oe, 1);
    tick();
    check_eq("b2b_g1_rdy", d_ready, 1);
    check_eq("b2b_g1_rdata", d_rdata, 32'hA1);
    tick();
    d_addr = 32'h24; mem_rdata = 32'hB2;
    check_eq("b2b_idle_rdy", d_ready, 0);
    check_eq("b2b_idle_busy", busy, 0);
    tick();
    check_eq("b2b_g2_addr", mem_addr, 32'h24);
    check_eq("b2b_g2_oe", mem_oe, 1);
    check_eq("b2b_g2_hold", d_rdata, 32'hA1);
    tick();
    check_eq("b2b_g2_rdy", d_ready, 1);
    check_eq("b2b_g2_rdata", d_rdata, 32'hB2);
    d_rd = 1'b0; mem_ready = 1'b0;
    tick();

    // Starvation control: D,D,D,I,D,D,D,I with a grant every third cycle
    d_rd = 1'b1; i_rd = 1'b1; d_addr = 32'h100; i_addr = 32'h200;
    mem_ready = 1'b1; mem_rdata = 32'h5555_0000;
    for (int unsigned c = 1; c <= 24; c++) begin
      tick();
      exp_i = (c == 11) || (c == 23);
      exp_d = (c % 3 == 2) && !exp_i;
      check_eq($sformatf("stv_d_rdy_c%0d", c), d_ready, exp_d);
      check_eq($sformatf("stv_i_rdy_c%0d", c), i_ready, exp_i);
      if (c % 3 == 1)
        check_eq($sformatf("stv_addr_c%0d", c), mem_addr,
                 ((c == 10) || (c == 22)) ? 32'h200 : 32'h100);
    end
    d_rd = 1'b0; i_rd = 1'b0; mem_ready = 1'b0;
    tick();
    check_eq("stv_end_busy", busy, 0);

    // Watchdog: mem_ready never arrives
    d_rd = 1'b1; d_addr = 32'h30; mem_rdata = 32'hFFFF_FFFF;
    oe_cnt = 0; done_at = 0;
    for (int unsigned c = 1; c <= 400; c++) begin
      tick();
      if (mem_oe) oe_cnt++;
      if (d_ready) begin
        done_at = c;
        break;
      end
    end
    check_eq("tmo_done_cycle", done_at, 256);
    check_eq("tmo_grant_cycles", oe_cnt, 255);
    check_eq("tmo_bus_err", bus_err, 1);
    check_eq("tmo_i_rdy", i_ready, 0);
    check_eq("tmo_rdata_kept", d_rdata, 32'h5555_0000);
    d_rd = 1'b0;
    tick();
    check_eq("tmo_rdy_pulse", d_ready, 0);
    tick(); tick();
    check_eq("tmo_err_sticky", bus_err, 1);
    check_eq("tmo_idle", busy, 0);

    // Reset in cycle 2 of a data grant
    d_rd = 1'b1; d_addr = 32'h50;
    tick(); tick();
    check_eq("rmid_oe_before", mem_oe, 1);
    #1 reset = 1'b1;
    #1;
    check_eq("rmid_oe", mem_oe, 0);
    check_eq("rmid_busy", busy, 0);
    check_eq("rmid_addr", mem_addr, 0);
    check_eq("rmid_err", bus_err, 0);
    d_rd = 1'b0;
    tick();
    check_eq("rmid_no_rdy", d_ready, 0);
    tick();
    reset = 1'b0;
    check_eq("rmid_no_rdy2", d_ready, 0);
    d_rd = 1'b1; d_addr = 32'h60; mem_rdata = 32'hC3C3_C3C3; mem_ready = 1'b1;
    tick();
    check_eq("rmid_new_oe", mem_oe, 1);
    check_eq("rmid_new_addr", mem_addr, 32'h60);
    tick();
    check_eq("rmid_new_rdy", d_ready, 1);
    check_eq("rmid_new_rdata", d_rdata, 32'hC3C3_C3C3);
    check_eq("rmid_new_err", bus_err, 0);
    d_rd = 1'b0; mem_ready = 1'b0;
    tick();
    check_eq("rmid_new_pulse", d_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 32, address width.
REQ-002 SHALL have parameter DATA_W, 32, data word width.
REQ-003 SHALL have parameter STARVE_LIM, 3, max consecutive data grants while instr request pending.
REQ-004 SHALL have parameter TIMEOUT, 255, max cycles in a grant state without mem_ready.
REQ-005 SHALL use one clock and an asynchronous, active-high reset, with ports: clk in 1, rising-edge clock; reset in 1, asynchronous active-high reset.
REQ-006 SHALL have data-cache request ports: d_rd in 1, read request; d_wr in 1, write request; d_addr in ADDR_W, word address; d_wdata in DATA_W, write data.
REQ-007 SHALL have data-cache response ports: d_rdata out DATA_W, read data; d_ready out 1, completion pulse.
REQ-008 SHALL have instr-cache request ports: i_rd in 1, read request; i_addr in ADDR_W, word address.
REQ-009 SHALL have instr-cache response ports: i_rdata out DATA_W, read data; i_ready out 1, completion pulse.
REQ-010 SHALL have memory command ports: mem_oe out 1, read strobe; mem_we out 1, write strobe; mem_addr out ADDR_W; mem_wdata out DATA_W.
REQ-011 SHALL have memory response ports: mem_rdata in DATA_W; mem_ready in 1.
REQ-012 SHALL have status ports: busy out 1, state != IDLE; bus_err out 1, sticky timeout flag.

Function
REQ-013 SHALL implement FSM states IDLE, GNT_D, GNT_I, DONE, with all outputs registered.
REQ-014 SHALL, in IDLE, sample requests each edge and go to GNT_D (if d_rd|d_wr) or GNT_I (if i_rd); if none, stay in IDLE.
REQ-015 SHALL give data priority on simultaneous requests, except when starve_cnt == STARVE_LIM, where instr wins.
REQ-016 SHALL make starve_cnt increment on each GNT_D entry while i_rd is high, clear on GNT_I entry, and saturate at STARVE_LIM.
REQ-017 SHALL latch address, write data and the operation in registers on grant entry; mem_addr/mem_wdata stay stable through the grant.
REQ-018 SHALL, in GNT_D: assert mem_we when d_wr (d_wr wins if d_rd and d_wr are both high), otherwise assert mem_oe; never both.
REQ-019 SHALL, in GNT_I: assert mem_oe only.
REQ-020 SHALL go to DONE on the edge where mem_ready is sampled high in a grant state; at that edge mem_rdata is latched into the granted requester's rdata.
REQ-021 SHALL, in DONE: deassert mem_oe/mem_we, pulse d_ready or i_ready for exactly one cycle, then return to IDLE.
REQ-022 SHALL hold d_rdata/i_rdata until the next completed read for that port.
REQ-023 SHALL deliver minimum latency as: request sampled in cycle 0; command in cycle 1; mem_ready in cycle k ≥ 1; ready pulse in cycle k+1; IDLE in cycle k+2.
REQ-024 SHALL define the handshake as: requester holds request and operands until its ready pulse, and drops the request the cycle after.
REQ-025 SHALL ignore request changes during a grant; a request dropped mid-grant still completes.
REQ-026 SHALL count cycles in a grant state with a watchdog; at TIMEOUT, go to DONE, set bus_err, pulse ready, and leave rdata unchanged.
REQ-027 SHALL ignore mem_ready in IDLE and DONE.

Reset
REQ-028 SHALL, on reset high, asynchronously force state IDLE; all outputs 0; starve_cnt, watchdog, latched address/data and rdata registers 0; bus_err 0.
REQ-029 SHALL abort an in-flight transaction on reset mid-grant, with no ready pulse; mem_oe/mem_we drop immediately.
REQ-030 SHALL return bus_err to 0 only on reset.

Structure
REQ-031 SHALL place the state enum, ADDR_W/DATA_W defaults and the STARVE_LIM/TIMEOUT defaults in shared package mem_arb_pkg.
REQ-032 SHALL implement the grant decision (requests, starve_cnt -> pick) as combinational sub-module mem_arb_pick; the FSM, counters and registers stay in mem_arbiter.

Verification
REQ-033 SHALL cover, for a single instr read with i_addr=0x40 and mem_ready at cycle 3: mem_oe in cycles 1-3, mem_addr=0x40, i_ready in cycle 4, i_rdata=mem_rdata.
REQ-034 SHALL cover, for d_wr=1 and d_rd=1 simultaneously, d_addr=0x10, d_wdata=0xDEADBEEF: mem_we only, mem_wdata=0xDEADBEEF, one d_ready pulse.
REQ-035 SHALL cover, for d_rd and i_rd continuously high with STARVE_LIM=3: grant order D,D,D,I,D,D,D,I; there are 2 idle cycles (DONE, IDLE) between grants.
REQ-036 SHALL cover, when mem_ready is never asserted with TIMEOUT=255: DONE entered after 255 grant cycles, bus_err=1 and stays 1, one ready pulse.
REQ-037 SHALL cover reset asserted in cycle 2 of GNT_D: outputs 0 immediately, no d_ready, next request accepted normally after reset release.
REQ-038 SHALL cover a single d_rd followed by a new d_rd in the cycle after d_ready: second grant starts with no lost request, and d_rdata is updated in order.
